// File: rtl/wb_common_pkg.sv
// Shared Wishbone B3 definitions: cycle-type and burst-type codes, the
// watchdog state encoding, and a small saturating-count helper.
package wb_common_pkg;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_CONST   = 3'b001;
  localparam logic [2:0] CTI_INCR    = 3'b010;
  localparam logic [2:0] CTI_EOB     = 3'b111;

  localparam logic [1:0] BTE_LINEAR  = 2'b00;
  localparam logic [1:0] BTE_WRAP4   = 2'b01;
  localparam logic [1:0] BTE_WRAP8   = 2'b10;
  localparam logic [1:0] BTE_WRAP16  = 2'b11;

  typedef enum logic {
    IDLE  = 1'b0,
    ABORT = 1'b1
  } wd_state_e;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/wb_bus_watchdog_cnt.sv
// Strobe-age counter. Counts strobed, unterminated cycles; "limit" marks the
// last cycle before an abort. It wraps to zero when incremented at the limit,
// because the top is in ABORT for the following cycle and a fresh strobe
// must start counting from zero afterwards.
module wb_bus_watchdog_cnt #(
  parameter int CNT_W   = 8,
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic clr,
  output logic limit
);

  localparam logic [CNT_W-1:0] LIMIT_VAL = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] cnt;

  assign limit = (cnt == LIMIT_VAL);

  // count register: clear has priority, wrap at the limit
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (inc) begin
      cnt <= limit ? '0 : cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/wb_bus_watchdog.sv
// Wishbone bus watchdog between an or1200 master port and the interconnect.
// Requests and responses pass through combinationally; a strobe that stays
// unterminated for TIMEOUT cycles is aborted towards the slave and answered
// with a one-cycle error towards the CPU.
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | pass-through; covers both no-access and counting (RUN) cycles
// ABORT | one cycle: slave request gated off, err returned to the master
module wb_bus_watchdog
  import wb_common_pkg::*;
#(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 8
) (
  input  logic            wb_clk_i,
  input  logic            wb_rst_i,
  input  logic            enable_i,
  input  logic            clr_i,

  input  logic [AW-1:0]   wbm_adr_i,
  input  logic [DW-1:0]   wbm_dat_i,
  input  logic [DW/8-1:0] wbm_sel_i,
  input  logic            wbm_we_i,
  input  logic            wbm_cyc_i,
  input  logic            wbm_stb_i,
  input  logic [2:0]      wbm_cti_i,
  input  logic [1:0]      wbm_bte_i,
  output logic [DW-1:0]   wbm_dat_o,
  output logic            wbm_ack_o,
  output logic            wbm_err_o,
  output logic            wbm_rty_o,

  output logic [AW-1:0]   wbs_adr_o,
  output logic [DW-1:0]   wbs_dat_o,
  output logic [DW/8-1:0] wbs_sel_o,
  output logic            wbs_we_o,
  output logic            wbs_cyc_o,
  output logic            wbs_stb_o,
  output logic [2:0]      wbs_cti_o,
  output logic [1:0]      wbs_bte_o,
  input  logic [DW-1:0]   wbs_dat_i,
  input  logic            wbs_ack_i,
  input  logic            wbs_err_i,
  input  logic            wbs_rty_i,

  output logic            irq_o,
  output logic [AW-1:0]   err_adr_o,
  output logic [7:0]      err_cnt_o
);

  wd_state_e state, state_nxt;

  logic strobe;
  logic term;
  logic cnt_inc;
  logic cnt_clr;
  logic cnt_limit;
  logic timeout;

  assign strobe  = wbm_cyc_i & wbm_stb_i;
  assign term    = wbs_ack_i | wbs_err_i | wbs_rty_i;
  // Counting only happens in pass-through; any other cycle restarts the age.
  assign cnt_inc = (state == IDLE) & enable_i & strobe & ~term;
  assign cnt_clr = ~cnt_inc;
  assign timeout = cnt_inc & cnt_limit;

  wb_bus_watchdog_cnt #(
    .CNT_W   (CNT_W),
    .TIMEOUT (TIMEOUT)
  ) u_cnt (
    .clk   (wb_clk_i),
    .rst   (wb_rst_i),
    .inc   (cnt_inc),
    .clr   (cnt_clr),
    .limit (cnt_limit)
  );

  // state register
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // next state: ABORT is entered on timeout and always lasts one cycle
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (timeout) state_nxt = ABORT;
      ABORT:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign wbs_adr_o = wbm_adr_i;
  assign wbs_dat_o = wbm_dat_i;
  assign wbs_sel_o = wbm_sel_i;
  assign wbs_we_o  = wbm_we_i;
  assign wbs_cti_o = wbm_cti_i;
  assign wbs_bte_o = wbm_bte_i;
  assign wbm_dat_o = wbs_dat_i;

  // handshake mux: pass-through, or gate the slave and answer err in ABORT
  always_comb begin
    wbs_cyc_o = wbm_cyc_i;
    wbs_stb_o = wbm_stb_i;
    wbm_ack_o = wbs_ack_i;
    wbm_err_o = wbs_err_i;
    wbm_rty_o = wbs_rty_i;
    if (state == ABORT) begin
      wbs_cyc_o = 1'b0;
      wbs_stb_o = 1'b0;
      wbm_ack_o = 1'b0;
      wbm_err_o = 1'b1;
      wbm_rty_o = 1'b0;
    end
  end

  // fault log: the irq set on ABORT exit beats a coincident clear
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      irq_o     <= 1'b0;
      err_adr_o <= '0;
      err_cnt_o <= '0;
    end else if (state == ABORT) begin
      irq_o     <= 1'b1;
      err_adr_o <= wbm_adr_i;
      err_cnt_o <= sat_inc8(err_cnt_o);
    end else if (clr_i) begin
      irq_o     <= 1'b0;
    end
  end

endmodule

// File: tb/tb_wb_bus_watchdog.sv
// Bench for wb_bus_watchdog with TIMEOUT=4. The driver pushes the expected
// response of each beat into a queue; a monitor on the falling edge pops and
// checks every response the DUT presents to the master.
module tb_wb_bus_watchdog;
  import wb_common_pkg::*;

  localparam int          TO   = 4;
  localparam logic [31:0] DKEY = 32'hA5A5_3C3C;

  logic        wb_clk_i = 1'b0;
  logic        wb_rst_i = 1'b1;
  logic        enable_i = 1'b1;
  logic        clr_i    = 1'b0;
  logic [31:0] wbm_adr_i = '0;
  logic [31:0] wbm_dat_i = '0;
  logic [3:0]  wbm_sel_i = '0;
  logic        wbm_we_i  = 1'b0;
  logic        wbm_cyc_i = 1'b0;
  logic        wbm_stb_i = 1'b0;
  logic [2:0]  wbm_cti_i = '0;
  logic [1:0]  wbm_bte_i = '0;
  logic [31:0] wbm_dat_o;
  logic        wbm_ack_o, wbm_err_o, wbm_rty_o;
  logic [31:0] wbs_adr_o, wbs_dat_o;
  logic [3:0]  wbs_sel_o;
  logic        wbs_we_o, wbs_cyc_o, wbs_stb_o;
  logic [2:0]  wbs_cti_o;
  logic [1:0]  wbs_bte_o;
  logic [31:0] wbs_dat_i;
  logic        wbs_ack_i;
  logic        wbs_err_i = 1'b0;
  logic        wbs_rty_i = 1'b0;
  logic        irq_o;
  logic [31:0] err_adr_o;
  logic [7:0]  err_cnt_o;

  wb_bus_watchdog #(.AW(32), .DW(32), .TIMEOUT(TO), .CNT_W(8)) dut (
    .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i), .enable_i(enable_i), .clr_i(clr_i),
    .wbm_adr_i(wbm_adr_i), .wbm_dat_i(wbm_dat_i), .wbm_sel_i(wbm_sel_i),
    .wbm_we_i(wbm_we_i), .wbm_cyc_i(wbm_cyc_i), .wbm_stb_i(wbm_stb_i),
    .wbm_cti_i(wbm_cti_i), .wbm_bte_i(wbm_bte_i), .wbm_dat_o(wbm_dat_o),
    .wbm_ack_o(wbm_ack_o), .wbm_err_o(wbm_err_o), .wbm_rty_o(wbm_rty_o),
    .wbs_adr_o(wbs_adr_o), .wbs_dat_o(wbs_dat_o), .wbs_sel_o(wbs_sel_o),
    .wbs_we_o(wbs_we_o), .wbs_cyc_o(wbs_cyc_o), .wbs_stb_o(wbs_stb_o),
    .wbs_cti_o(wbs_cti_o), .wbs_bte_o(wbs_bte_o), .wbs_dat_i(wbs_dat_i),
    .wbs_ack_i(wbs_ack_i), .wbs_err_i(wbs_err_i), .wbs_rty_i(wbs_rty_i),
    .irq_o(irq_o), .err_adr_o(err_adr_o), .err_cnt_o(err_cnt_o)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  int cyc_n = 0;
  always @(posedge wb_clk_i) cyc_n <= cyc_n + 1;

  // Slave model: acks after ack_delay wait cycles, watching the master-side
  // strobe so that a late ack still shows up while the DUT is aborting.
  logic slave_en  = 1'b0;
  int   ack_delay = 2;
  int   slave_wait = 0;
  assign wbs_ack_i = slave_en && wbm_cyc_i && wbm_stb_i && (slave_wait == ack_delay);
  assign wbs_dat_i = wbs_adr_o ^ DKEY;
  always @(posedge wb_clk_i) begin
    if (wbm_cyc_i && wbm_stb_i && !wbs_ack_i) slave_wait <= slave_wait + 1;
    else                                     slave_wait <= 0;
  end

  typedef struct {
    logic        is_err;
    logic [31:0] adr;
    int          cyc;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   t0 = 0;
  int   tests = 0;
  int   fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, req);
    end
  endtask

  // monitor: every response the master sees must match the head of the queue
  always @(negedge wb_clk_i) begin
    if (!wb_rst_i && (wbm_ack_o || wbm_err_o || wbm_rty_o)) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_resp ack=%0b err=%0b rty=%0b adr=0x%08h",
                 wbm_ack_o, wbm_err_o, wbm_rty_o, wbm_adr_i);
      end else begin
        mon_e = exp_q.pop_front();
        check("resp_err", 32'(wbm_err_o), 32'(mon_e.is_err));
        check("resp_ack", 32'(wbm_ack_o), 32'(!mon_e.is_err));
        check("resp_rty", 32'(wbm_rty_o), 32'd0);
        check("resp_cycle", 32'(cyc_n - t0), 32'(mon_e.cyc));
        if (mon_e.is_err) begin
          check("abort_cyc_gated", {30'd0, wbs_cyc_o, wbs_stb_o}, 32'd0);
        end else begin
          check("ack_data", wbm_dat_o, mon_e.adr ^ DKEY);
          check("ack_adr", wbs_adr_o, mon_e.adr);
        end
      end
    end
  end

  task automatic start_beat(input logic [31:0] adr, input logic [2:0] cti,
                            input logic exp_err, input int exp_cyc);
    exp_q.push_back('{exp_err, adr, exp_cyc});
    wbm_adr_i = adr;
    wbm_dat_i = ~adr;
    wbm_sel_i = 4'hF;
    wbm_we_i  = 1'b0;
    wbm_cti_i = cti;
    wbm_bte_i = BTE_LINEAR;
    wbm_cyc_i = 1'b1;
    wbm_stb_i = 1'b1;
    t0 = cyc_n;
  endtask

  // waits for a termination on the falling edge; counts strobed slave cycles
  task automatic wait_term(output logic got, output logic is_err, output int stbc);
    got = 1'b0;
    is_err = 1'b0;
    stbc = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge wb_clk_i);
      if (wbs_stb_o) stbc++;
      if (wbm_ack_o || wbm_err_o || wbm_rty_o) begin
        got = 1'b1;
        is_err = wbm_err_o;
        break;
      end
    end
    if (!got) begin
      tests++;
      fails++;
      $display("FAIL term_timeout actual=none required=response adr=0x%08h", wbm_adr_i);
    end
  endtask

  task automatic end_access();
    wbm_cyc_i = 1'b0;
    wbm_stb_i = 1'b0;
    wbm_cti_i = CTI_CLASSIC;
    @(posedge wb_clk_i); #1;
  endtask

  task automatic do_access(input logic [31:0] adr, input int beats,
                           input logic exp_err, input int exp_cyc, output int stbc);
    logic [31:0] a;
    logic [2:0]  cti;
    logic        got, is_err;
    a = adr;
    stbc = 0;
    for (int b = 0; b < beats; b++) begin
      cti = (beats == 1) ? CTI_CLASSIC : ((b == beats - 1) ? CTI_EOB : CTI_INCR);
      start_beat(a, cti, exp_err, exp_cyc);
      wait_term(got, is_err, stbc);
      @(posedge wb_clk_i); #1;
      if (!got || is_err) break;
      a = a + 32'd4;
    end
    end_access();
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge wb_clk_i);
    #1;
  endtask

  initial begin
    int   stbc;
    int   bad;
    logic got, is_err;

    idle(3);
    wb_rst_i = 1'b0;
    @(negedge wb_clk_i);
    check("rst_irq", 32'(irq_o), 32'd0);
    check("rst_err_adr", err_adr_o, 32'd0);
    check("rst_err_cnt", 32'(err_cnt_o), 32'd0);
    check("rst_resp_idle", {29'd0, wbm_ack_o, wbm_err_o, wbm_rty_o}, 32'd0);
    check("rst_slave_idle", {30'd0, wbs_cyc_o, wbs_stb_o}, 32'd0);
    @(posedge wb_clk_i); #1;

    // pass-through read, slave acks in cycle 2
    slave_en = 1'b1; ack_delay = 2;
    do_access(32'h1000_0010, 1, 1'b0, 2, stbc);
    check("pass_irq", 32'(irq_o), 32'd0);
    check("pass_err_cnt", 32'(err_cnt_o), 32'd0);

    // ack in the limit cycle wins over the abort
    ack_delay = 3;
    do_access(32'h1000_0020, 1, 1'b0, 3, stbc);

    // burst, each beat acked after 3 wait cycles
    do_access(32'h2000_0000, 4, 1'b0, 3, stbc);
    check("burst_err_cnt", 32'(err_cnt_o), 32'd0);
    check("burst_irq", 32'(irq_o), 32'd0);

    // no slave: abort in cycle 4
    slave_en = 1'b0;
    do_access(32'h9000_0000, 1, 1'b1, TO, stbc);
    check("timeout_stb_cycles", 32'(stbc), 32'(TO));
    check("timeout_err_adr", err_adr_o, 32'h9000_0000);
    check("timeout_irq", 32'(irq_o), 32'd1);
    check("timeout_err_cnt", 32'(err_cnt_o), 32'd1);

    // ack in cycle 4 lands in ABORT and is swallowed
    slave_en = 1'b1; ack_delay = 4;
    do_access(32'hA000_0040, 1, 1'b1, TO, stbc);
    check("late_ack_err_adr", err_adr_o, 32'hA000_0040);
    check("late_ack_err_cnt", 32'(err_cnt_o), 32'd2);

    // clr pulse
    clr_i = 1'b1;
    @(posedge wb_clk_i); #1;
    clr_i = 1'b0;
    check("clr_irq", 32'(irq_o), 32'd0);
    check("clr_keeps_adr", err_adr_o, 32'hA000_0040);
    check("clr_keeps_cnt", 32'(err_cnt_o), 32'd2);

    // clr held through an abort: the irq set on ABORT exit wins
    slave_en = 1'b0;
    clr_i = 1'b1;
    start_beat(32'h9000_0100, CTI_CLASSIC, 1'b1, TO);
    wait_term(got, is_err, stbc);
    @(posedge wb_clk_i); #1;
    clr_i = 1'b0;
    check("clr_vs_set_irq", 32'(irq_o), 32'd1);
    check("clr_vs_set_cnt", 32'(err_cnt_o), 32'd3);
    end_access();

    // master drops cyc mid-count: no abort
    start_beat(32'h9000_0200, CTI_CLASSIC, 1'b0, 0);
    void'(exp_q.pop_back());
    idle(3);
    end_access();
    idle(3);
    check("cyc_drop_err_cnt", 32'(err_cnt_o), 32'd3);
    slave_en = 1'b1; ack_delay = 3;
    do_access(32'h1000_0030, 1, 1'b0, 3, stbc);

    // enable dropped for one cycle mid-count restarts the count
    slave_en = 1'b0;
    start_beat(32'h9000_0300, CTI_CLASSIC, 1'b1, 8);
    idle(3);
    enable_i = 1'b0;
    idle(1);
    enable_i = 1'b1;
    wait_term(got, is_err, stbc);
    @(posedge wb_clk_i); #1;
    end_access();
    check("en_glitch_err_cnt", 32'(err_cnt_o), 32'd4);
    check("en_glitch_err_adr", err_adr_o, 32'h9000_0300);

    // disabled watchdog with a hung slave never aborts
    enable_i = 1'b0;
    start_beat(32'h9000_0400, CTI_CLASSIC, 1'b0, 0);
    void'(exp_q.pop_back());
    bad = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge wb_clk_i);
      if (!wbs_cyc_o || !wbs_stb_o || wbm_err_o) bad++;
    end
    check("disabled_hung_bad_cycles", 32'(bad), 32'd0);
    @(posedge wb_clk_i); #1;
    end_access();
    enable_i = 1'b1;
    check("disabled_err_cnt", 32'(err_cnt_o), 32'd4);

    // 300 forced timeouts saturate the abort count
    for (int i = 0; i < 300; i++) begin
      do_access(32'hB000_0000 + 32'(i * 4), 1, 1'b1, TO, stbc);
    end
    check("sat_err_cnt", 32'(err_cnt_o), 32'd255);
    check("sat_err_adr", err_adr_o, 32'hB000_0000 + 32'(299 * 4));
    check("sat_irq", 32'(irq_o), 32'd1);

    // reset at the limit edge drops the pending abort
    start_beat(32'h9000_0500, CTI_CLASSIC, 1'b0, 0);
    void'(exp_q.pop_back());
    idle(3);
    wb_rst_i = 1'b1;
    idle(1);
    wb_rst_i = 1'b0;
    @(negedge wb_clk_i);
    check("rst_mid_no_err", 32'(wbm_err_o), 32'd0);
    check("rst_mid_irq", 32'(irq_o), 32'd0);
    check("rst_mid_err_adr", err_adr_o, 32'd0);
    check("rst_mid_err_cnt", 32'(err_cnt_o), 32'd0);
    @(posedge wb_clk_i); #1;
    end_access();

    idle(4);
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/wb_bus_watchdog.md
Name: wb_bus_watchdog

Overview:
- Wishbone B3 bus watchdog placed directly downstream of an or1200 master port (instruction or data), upstream of the Wishbone interconnect.
- Passes every access through combinationally.
- If the addressed slave does not terminate a strobed access within TIMEOUT cycles, it aborts the access towards the slave and returns a one-cycle error to the CPU, so unmapped or hung slaves raise a bus error instead of stalling the core.
- Logs the faulting address and raises a sticky interrupt for the PIC.

Parameters:
- AW, 32, Wishbone address width.
- DW, 32, Wishbone data width.
- TIMEOUT, 255, cycles a strobe may stay unterminated before abort; legal range 2..2^CNT_W-1.
- CNT_W, 8, width of the timeout counter.

Ports:
- wb_clk_i  in  1  clock.
- wb_rst_i  in  1  synchronous active-high reset.
- enable_i  in  1  1 = watchdog active; 0 = pure pass-through, never aborts.
- clr_i  in  1  one-cycle pulse; clears irq_o.
- wbm_adr_i/dat_i/sel_i/we_i/cyc_i/stb_i/cti_i/bte_i  in  AW/DW/DW/8/1/1/1/3/2  request from CPU master.
- wbm_dat_o/ack_o/err_o/rty_o  out  DW/1/1/1  response to CPU master.
- wbs_adr_o/dat_o/sel_o/we_o/cyc_o/stb_o/cti_o/bte_o  out  same widths  request to interconnect.
- wbs_dat_i/ack_i/err_i/rty_i  in  DW/1/1/1  response from interconnect.
- irq_o  out  1  sticky timeout interrupt.
- err_adr_o  out  AW  address of the most recent aborted access.
- err_cnt_o  out  8  saturating count of aborts.

Behaviour:
- Reset (synchronous, active-high):
  - state=IDLE, counter=0, irq_o=0, err_adr_o=0, err_cnt_o=0.
  - wbm_ack_o, wbm_err_o and wbm_rty_o follow the slave (0 while the slave is idle).
  - Reset mid-access drops any pending abort.
- States:
  - IDLE/RUN are the pass-through states.
  - ABORT lasts one cycle.
- Pass-through (IDLE/RUN):
  - All wbs_* request signals equal the wbm_* inputs combinationally.
  - All wbm_* responses equal the wbs_* responses.
  - Zero added latency.
- Termination and counter:
  - Termination is ack_i | err_i | rty_i from the slave.
  - On each edge with cyc&stb high, no termination and enable_i=1, the counter increments.
  - The counter clears on termination, on stb low, or on enable_i=0.
  - Bursts (cti=010) therefore restart the count at every beat ack.
- Timeout:
  - If the counter equals TIMEOUT-1, cyc&stb are high, there is no termination and enable_i=1 at an edge, the next state is ABORT.
  - Cycle 0 is the first strobed cycle, so wbm_err_o rises in cycle TIMEOUT.
- ABORT cycle:
  - wbs_cyc_o=0, wbs_stb_o=0.
  - wbm_err_o=1, wbm_ack_o=0, wbm_rty_o=0.
  - Slave responses are ignored, so a late ack is swallowed.
  - On the edge leaving ABORT: err_adr_o <= wbm_adr_i, irq_o <= 1, err_cnt_o increments and saturates at 255.
  - Next state is IDLE, counter=0.
- Simultaneous events:
  - A termination in the limit cycle wins: no abort, the response passes through.
  - In the ABORT exit cycle, a clr_i pulse loses to the irq set (irq_o remains 1).
  - clr_i in any other cycle clears irq_o on the next edge; err_adr_o and err_cnt_o are not cleared by clr_i.
- If the master drops cyc mid-count, the counter clears and no abort occurs.
- enable_i falling during a count clears the counter the same edge; an already-entered ABORT still completes.

Decomposition:
- Shared package wb_common_pkg:
  - Wishbone CTI constants (CLASSIC=000, INCR=010, EOB=111) and BTE constants.
  - Watchdog state enum {IDLE, ABORT}.
  - Shared by future Wishbone blocks.
- One sub-module is natural: wb_bus_watchdog_cnt.
  - Parameterised CNT_W/TIMEOUT counter with inc/clr inputs and a "limit" flag.
- Muxing and status registers remain in the top.

Test Plan:
- Basic pass-through: TIMEOUT=4, single read to a slave acking in cycle 2 -> wbm_ack_o in cycle 2, data passes unchanged, wbm_err_o never 1, irq_o=0.
- Timeout: TIMEOUT=4, read to adr 0x9000_0000 with no slave response -> stb seen cycles 0-3, wbm_err_o=1 only in cycle 4 with wbs_cyc_o=0, then err_adr_o=0x9000_0000, irq_o=1, err_cnt_o=1.
- Boundary ack: TIMEOUT=4, slave ack in cycle 3 -> normal ack, no err; ack in cycle 4 arrives during ABORT -> swallowed, master sees err only.
- Burst: TIMEOUT=4, 4-beat INCR burst where each beat is acked after 3 wait cycles -> all 4 acks pass, no abort, err_cnt_o=0.
- Controls: 300 forced timeouts -> err_cnt_o=255; clr_i pulse -> irq_o=0 next cycle; enable_i=0 with a hung slave for 1000 cycles -> no err and wbs_cyc_o stays 1; wb_rst_i during a count -> all status outputs 0.
